// File: rtl/decode_queue.sv
// ============================================================================
// Module   : decode_queue
// Purpose  : Circular instruction buffer between the fetch output register and
//            the multi-issue decoders. Accepts up to FETCH_W instructions per
//            cycle, presents up to ISSUE_W head entries per cycle, and never
//            presents a branch without its delay slot.
// Ports    : clk, reset (async, active-high), flush (sync clear)
//            in_valid/in_pc/in_instr/in_is_br/in_pred : fetch group
//            in_ready : room for a full fetch group (from registered count)
//            out_valid/out_pc/out_instr/out_pred/out_is_slot : head lanes
//            issue_cnt : lanes consumed this cycle (clamped to presented)
//            count : registered occupancy
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_queue #(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [FETCH_W-1:0]           in_valid,
    input  logic [FETCH_W*32-1:0]        in_pc,
    input  logic [FETCH_W*32-1:0]        in_instr,
    input  logic [FETCH_W-1:0]           in_is_br,
    input  logic [FETCH_W*33-1:0]        in_pred,
    output logic                         in_ready,
    output logic [ISSUE_W-1:0]           out_valid,
    output logic [ISSUE_W*32-1:0]        out_pc,
    output logic [ISSUE_W*32-1:0]        out_instr,
    output logic [ISSUE_W*33-1:0]        out_pred,
    output logic [ISSUE_W-1:0]           out_is_slot,
    input  logic [$clog2(ISSUE_W+1)-1:0] issue_cnt,
    output logic [CNT_W-1:0]             count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int ICNT_W = $clog2(ISSUE_W + 1);
    localparam int ENQ_W  = $clog2(FETCH_W + 1);

    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_FETCH_CNT = CNT_W'(FETCH_W);

    // Payload storage (not reset; validity is tracked by r_count only)
    logic [31:0] r_pc_mem    [DEPTH];
    logic [31:0] r_instr_mem [DEPTH];
    logic        r_br_mem    [DEPTH];
    logic [32:0] r_pred_mem  [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    // Only meaningful when ISSUE_W == 1: last issued entry was a branch
    logic             r_prev_br;

    logic             w_enq;
    logic [PTR_W-1:0] w_off [FETCH_W];
    logic [ENQ_W-1:0] w_nenq;
    logic [ENQ_W-1:0] w_nenq_eff;

    logic [PTR_W-1:0]   w_idx [ISSUE_W];
    logic [ISSUE_W:0]   w_avail;
    logic [ISSUE_W-1:0] w_br;
    logic               w_run;
    logic               w_ok;
    logic               w_prev;
    logic [ICNT_W-1:0]  w_npres;
    logic [ICNT_W-1:0]  w_ndeq;

    // Readiness looks only at the registered count, so issue_cnt never
    // reaches in_ready combinationally.
    assign in_ready   = (c_DEPTH_CNT - r_count) >= c_FETCH_CNT;
    assign w_enq      = in_ready && !flush;
    assign w_nenq_eff = w_enq ? w_nenq : '0;
    assign count      = r_count;

    // Compact valid lanes: each valid lane lands at tail + (number of valid
    // lanes below it).
    always_comb begin
        w_nenq = '0;
        for (int l = 0; l < FETCH_W; l++) begin
            w_off[l] = r_tail + PTR_W'(w_nenq);
            w_nenq   = w_nenq + ENQ_W'(in_valid[l]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            for (int l = 0; l < FETCH_W; l++) begin
                if (in_valid[l]) begin
                    r_pc_mem[w_off[l]]    <= in_pc[l*32 +: 32];
                    r_instr_mem[w_off[l]] <= in_instr[l*32 +: 32];
                    r_br_mem[w_off[l]]    <= in_is_br[l];
                    r_pred_mem[w_off[l]]  <= in_pred[l*33 +: 33];
                end
            end
        end
    end

    // Presentation. w_run keeps out_valid a contiguous low-order mask: the
    // first lane that cannot be presented blocks every lane above it. A
    // branch needs its slot in the next lane, which must exist and be
    // occupied; with a single lane the pairing is tracked by r_prev_br.
    always_comb begin
        w_avail     = '0;
        out_valid   = '0;
        out_is_slot = '0;
        out_pc      = '0;
        out_instr   = '0;
        out_pred    = '0;
        w_npres     = '0;
        w_run       = 1'b1;
        w_ok        = 1'b0;
        w_prev      = (ISSUE_W == 1) ? r_prev_br : 1'b0;
        for (int i = 0; i <= ISSUE_W; i++) begin
            w_avail[i] = CNT_W'(i) < r_count;
        end
        for (int i = 0; i < ISSUE_W; i++) begin
            w_idx[i] = r_head + PTR_W'(i);
            w_br[i]  = r_br_mem[w_idx[i]];
        end
        for (int i = 0; i < ISSUE_W; i++) begin
            if (ISSUE_W == 1) begin
                w_ok = w_avail[i];
            end else begin
                w_ok = w_avail[i] &&
                       (!w_br[i] || ((i + 1 < ISSUE_W) && w_avail[i+1]));
            end
            w_run                  = w_run && w_ok;
            out_valid[i]           = w_run;
            out_is_slot[i]         = w_run && w_prev;
            w_prev                 = w_br[i];
            w_npres                = w_npres + ICNT_W'(w_run);
            out_pc[i*32 +: 32]     = r_pc_mem[w_idx[i]];
            out_instr[i*32 +: 32]  = r_instr_mem[w_idx[i]];
            out_pred[i*33 +: 33]   = r_pred_mem[w_idx[i]];
        end
    end

    // Over-consumption is illegal; clamp so state stays consistent anyway.
    assign w_ndeq = (issue_cnt > w_npres) ? w_npres : issue_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_prev_br <= 1'b0;
        end else if (flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_prev_br <= 1'b0;
        end else begin
            r_head  <= r_head + PTR_W'(w_ndeq);
            r_tail  <= r_tail + PTR_W'(w_nenq_eff);
            r_count <= r_count + CNT_W'(w_nenq_eff) - CNT_W'(w_ndeq);
            if (w_ndeq != '0) begin
                r_prev_br <= (ISSUE_W == 1) ? w_br[0] : 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && !flush) begin
            assert (issue_cnt <= w_npres)
            else $error("decode_queue: issue_cnt %0d exceeds presented lanes %0d",
                        issue_cnt, w_npres);
        end
    end

endmodule

`default_nettype wire
